// File: rtl/maze_memory.sv
// Maze map store for the solver: loads wall rows, answers cell reads/marks,
// then streams the marked path back out one row per handshake.
module maze_memory #(
   parameter int maze_width = 6,
   parameter int MAZE_SIZE  = 64,
   parameter int LEN_W      = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [MAZE_SIZE-1:0]  load_data,
   input  logic [maze_width-1:0] row,
   input  logic [maze_width-1:0] col,
   input  logic                  maze_oe,
   input  logic                  maze_we,
   input  logic                  done,
   output logic                  maze_in,
   output logic                  solver_en,
   output logic [LEN_W-1:0]      path_len,
   output logic                  wall_violation,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [MAZE_SIZE-1:0]  dump_data
);

   typedef enum logic [1:0] {LOAD, SERVE, DUMP, FINISHED} state_t;

   state_t state_reg, state_next;

   logic [MAZE_SIZE-1:0]  wall_mem [MAZE_SIZE];
   logic [MAZE_SIZE-1:0]  path_mem [MAZE_SIZE];

   logic [maze_width-1:0] load_row_reg;
   logic [maze_width-1:0] dump_row_reg;
   logic [maze_width-1:0] dump_row_next;

   logic                  load_hs;
   logic                  dump_hs;
   logic                  mark;
   logic                  finish_solve;
   logic                  last_load;
   logic                  last_dump;
   logic [MAZE_SIZE-1:0]  wall_sel;
   logic [MAZE_SIZE-1:0]  path_sel;
   logic [MAZE_SIZE-1:0]  mark_mask;
   logic [MAZE_SIZE-1:0]  path_row0;

   assign load_ready    = (state_reg == LOAD);
   assign load_hs       = load_valid && load_ready;
   assign dump_hs       = dump_valid && dump_ready && (state_reg == DUMP);
   assign mark          = (state_reg == SERVE) && maze_we;
   assign finish_solve  = (state_reg == SERVE) && done;
   assign last_load     = (load_row_reg == maze_width'(MAZE_SIZE - 1));
   assign last_dump     = (dump_row_reg == maze_width'(MAZE_SIZE - 1));
   assign dump_row_next = dump_row_reg + 1'b1;
   assign wall_sel      = wall_mem[row];
   assign path_sel      = path_mem[row];

   generate
      for (genvar gi = 0; gi < MAZE_SIZE; gi++) begin : g_mask
         assign mark_mask[gi] = (col == maze_width'(gi));
      end
   endgenerate

   // A mark issued together with done must already show in the first dumped row.
   assign path_row0 = path_mem[0] | ((mark && (row == '0)) ? mark_mask : '0);

   always_ff @(posedge clk) begin
      if (rst) state_reg <= LOAD;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD:     if (load_hs && last_load) state_next = SERVE;
         SERVE:    if (done)                 state_next = DUMP;
         DUMP:     if (dump_hs && last_dump) state_next = FINISHED;
         FINISHED: state_next = FINISHED;
         default:  state_next = LOAD;
      endcase
   end

   // Map arrays carry no reset; stale path rows are wiped as each row loads.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_hs) begin
            wall_mem[load_row_reg] <= load_data;
            path_mem[load_row_reg] <= '0;
         end else if (mark) begin
            path_mem[row] <= path_sel | mark_mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_row_reg   <= '0;
         dump_row_reg   <= '0;
         maze_in        <= 1'b0;
         solver_en      <= 1'b0;
         path_len       <= '0;
         wall_violation <= 1'b0;
         dump_valid     <= 1'b0;
         dump_data      <= '0;
      end else begin
         if (load_hs) begin
            load_row_reg <= load_row_reg + 1'b1;
            if (last_load) solver_en <= 1'b1;
         end

         if ((state_reg == SERVE) && maze_oe) maze_in <= wall_sel[col];

         if (mark) begin
            if (!path_sel[col] && (path_len != '1)) path_len <= path_len + 1'b1;
            if (wall_sel[col]) wall_violation <= 1'b1;
         end

         if (finish_solve) begin
            solver_en    <= 1'b0;
            dump_valid   <= 1'b1;
            dump_data    <= path_row0;
            dump_row_reg <= '0;
         end

         if (dump_hs) begin
            dump_row_reg <= dump_row_next;
            if (last_dump) dump_valid <= 1'b0;
            else           dump_data  <= path_mem[dump_row_next];
         end
      end
   end

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: load, serve, dump, finish and reset-mid-dump scenarios.
module tb_maze_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [63:0] load_data;
   logic [5:0]  row;
   logic [5:0]  col;
   logic        maze_oe;
   logic        maze_we;
   logic        done;
   logic        maze_in;
   logic        solver_en;
   logic [12:0] path_len;
   logic        wall_violation;
   logic        dump_valid;
   logic        dump_ready;
   logic [63:0] dump_data;

   int checks = 0;
   int errors = 0;

   maze_memory #(.maze_width(6), .MAZE_SIZE(64), .LEN_W(13)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .done(done),
      .maze_in(maze_in), .solver_en(solver_en), .path_len(path_len),
      .wall_violation(wall_violation),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_valid = 0; load_data = '0; row = '0; col = '0;
      maze_oe = 0; maze_we = 0; done = 0; dump_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      tick(); tick();
      checks++;
      if (load_ready !== 1'b1 || solver_en !== 1'b0 || maze_in !== 1'b0 || path_len !== 13'd0 ||
          wall_violation !== 1'b0 || dump_valid !== 1'b0 || dump_data !== 64'd0) begin
         errors++;
         $display("FAIL reset: load_ready=%b solver_en=%b maze_in=%b path_len=%0d wv=%b dump_valid=%b dump_data=%h, required 1 0 0 0 0 0 0",
                  load_ready, solver_en, maze_in, path_len, wall_violation, dump_valid, dump_data);
      end
      $display("reset: load_ready=%b solver_en=%b path_len=%0d", load_ready, solver_en, path_len);
      rst = 0;
   endtask

   task automatic test_load_ignores_solver();
      row = 6'd5; col = 6'd10; maze_we = 1; maze_oe = 1; done = 1;
      tick(); tick();
      idle_inputs();
      checks++;
      if (path_len !== 13'd0 || load_ready !== 1'b1 || solver_en !== 1'b0 || maze_in !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_ignore: path_len=%0d load_ready=%b solver_en=%b maze_in=%b dump_valid=%b, required 0 1 0 0 0",
                  path_len, load_ready, solver_en, maze_in, dump_valid);
      end
      $display("load_ignore: path_len=%0d load_ready=%b", path_len, load_ready);
   endtask

   task automatic test_load(input logic [63:0] fill, input bit gap);
      for (int r = 0; r < 64; r++) begin
         if (gap && r == 10) begin
            load_valid = 0;
            tick(); tick();
            checks++;
            if (load_ready !== 1'b1 || solver_en !== 1'b0) begin
               errors++;
               $display("FAIL load_gap: load_ready=%b solver_en=%b, required 1 0", load_ready, solver_en);
            end
         end
         if (r == 63) begin
            checks++;
            if (load_ready !== 1'b1) begin
               errors++;
               $display("FAIL load_ready_last: load_ready=%b, required 1", load_ready);
            end
         end
         load_valid = 1;
         load_data  = (r == 5) ? 64'h0 : fill;
         tick();
      end
      idle_inputs();
      checks++;
      if (load_ready !== 1'b0 || solver_en !== 1'b1) begin
         errors++;
         $display("FAIL load_done: load_ready=%b solver_en=%b, required 0 1", load_ready, solver_en);
      end
      $display("load: fill=%h gap=%0d load_ready=%b solver_en=%b", fill, gap, load_ready, solver_en);
   endtask

   task automatic test_read();
      maze_oe = 1; row = 6'd5; col = 6'd10;
      tick();
      maze_oe = 0;
      checks++;
      if (maze_in !== 1'b0) begin
         errors++;
         $display("FAIL read_5_10: maze_in=%b, required 0", maze_in);
      end
      $display("read (5,10): maze_in=%b", maze_in);
      maze_oe = 1; row = 6'd4; col = 6'd10;
      tick();
      maze_oe = 0; row = 6'd5;
      checks++;
      if (maze_in !== 1'b1) begin
         errors++;
         $display("FAIL read_4_10: maze_in=%b, required 1", maze_in);
      end
      $display("read (4,10): maze_in=%b", maze_in);
      tick(); tick();
      checks++;
      if (maze_in !== 1'b1) begin
         errors++;
         $display("FAIL read_hold: maze_in=%b, required 1", maze_in);
      end
      $display("read hold: maze_in=%b", maze_in);
   endtask

   task automatic test_mark();
      maze_we = 1; row = 6'd5; col = 6'd10;
      tick(); tick();
      col = 6'd11;
      tick();
      maze_we = 0;
      checks++;
      if (path_len !== 13'd2 || wall_violation !== 1'b0) begin
         errors++;
         $display("FAIL mark_free: path_len=%0d wv=%b, required 2 0", path_len, wall_violation);
      end
      $display("mark (5,10)x2 (5,11): path_len=%0d wv=%b", path_len, wall_violation);
      maze_we = 1; row = 6'd4; col = 6'd10;
      tick();
      maze_we = 0;
      checks++;
      if (path_len !== 13'd3 || wall_violation !== 1'b1) begin
         errors++;
         $display("FAIL mark_wall: path_len=%0d wv=%b, required 3 1", path_len, wall_violation);
      end
      $display("mark (4,10): path_len=%0d wv=%b", path_len, wall_violation);
      maze_we = 1; maze_oe = 1; row = 6'd5; col = 6'd12;
      tick();
      maze_we = 0; maze_oe = 0;
      checks++;
      if (maze_in !== 1'b0 || path_len !== 13'd4) begin
         errors++;
         $display("FAIL read_mark_same: maze_in=%b path_len=%0d, required 0 4", maze_in, path_len);
      end
      $display("read+mark (5,12): maze_in=%b path_len=%0d", maze_in, path_len);
   endtask

   task automatic test_serve_ignores_load();
      load_valid = 1; load_data = 64'h0;
      tick(); tick();
      load_valid = 0;
      maze_oe = 1; row = 6'd4; col = 6'd10;
      tick();
      maze_oe = 0;
      checks++;
      if (maze_in !== 1'b1 || path_len !== 13'd4 || load_ready !== 1'b0 || solver_en !== 1'b1) begin
         errors++;
         $display("FAIL serve_ignore: maze_in=%b path_len=%0d load_ready=%b solver_en=%b, required 1 4 0 1",
                  maze_in, path_len, load_ready, solver_en);
      end
      $display("serve_ignore: maze_in=%b path_len=%0d", maze_in, path_len);
   endtask

   function automatic logic [63:0] exp_row(input int r);
      if (r == 4) return 64'h0000_0000_0000_0400;
      if (r == 5) return 64'h0000_0000_0000_3C00;
      return 64'h0;
   endfunction

   task automatic test_done_dump();
      done = 1; maze_we = 1; row = 6'd5; col = 6'd13;
      tick();
      done = 0; maze_we = 0;
      checks++;
      if (path_len !== 13'd5 || solver_en !== 1'b0 || dump_valid !== 1'b1 || dump_data !== 64'h0) begin
         errors++;
         $display("FAIL done_enter: path_len=%0d solver_en=%b dump_valid=%b dump_data=%h, required 5 0 1 0",
                  path_len, solver_en, dump_valid, dump_data);
      end
      $display("done: path_len=%0d solver_en=%b dump_valid=%b", path_len, solver_en, dump_valid);
      // Late marks during the dump must not reach the map or the counter.
      maze_we = 1; row = 6'd20; col = 6'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dump_valid !== 1'b1 || dump_data !== 64'h0) begin
            errors++;
            $display("FAIL dump_stall: dump_valid=%b dump_data=%h, required 1 0", dump_valid, dump_data);
         end
      end
      for (int r = 0; r < 64; r++) begin
         checks++;
         if (dump_valid !== 1'b1 || dump_data !== exp_row(r)) begin
            errors++;
            $display("FAIL dump_row%0d: dump_valid=%b dump_data=%h, required 1 %h", r, dump_valid, dump_data, exp_row(r));
         end
         if (r == 4 || r == 5) $display("dump row %0d: %h", r, dump_data);
         dump_ready = 1;
         tick();
      end
      dump_ready = 0;
      checks++;
      if (dump_valid !== 1'b0 || path_len !== 13'd5) begin
         errors++;
         $display("FAIL dump_end: dump_valid=%b path_len=%0d, required 0 5", dump_valid, path_len);
      end
      $display("dump end: dump_valid=%b path_len=%0d", dump_valid, path_len);
   endtask

   task automatic test_finished();
      maze_we = 1; row = 6'd5; col = 6'd20; done = 1; load_valid = 1; dump_ready = 1;
      tick(); tick(); tick();
      idle_inputs();
      checks++;
      if (path_len !== 13'd5 || wall_violation !== 1'b1 || dump_valid !== 1'b0 || load_ready !== 1'b0 || solver_en !== 1'b0) begin
         errors++;
         $display("FAIL finished: path_len=%0d wv=%b dump_valid=%b load_ready=%b solver_en=%b, required 5 1 0 0 0",
                  path_len, wall_violation, dump_valid, load_ready, solver_en);
      end
      $display("finished: path_len=%0d wv=%b", path_len, wall_violation);
   endtask

   task automatic test_reset_mid_dump();
      rst = 1; tick(); rst = 0;
      test_load(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      maze_we = 1; row = 6'd4; col = 6'd10;
      tick();
      row = 6'd5; col = 6'd12;
      tick();
      maze_we = 0; done = 1;
      tick();
      done = 0;
      checks++;
      if (path_len !== 13'd2 || wall_violation !== 1'b1 || dump_valid !== 1'b1) begin
         errors++;
         $display("FAIL second_run: path_len=%0d wv=%b dump_valid=%b, required 2 1 1", path_len, wall_violation, dump_valid);
      end
      dump_ready = 1;
      for (int r = 0; r < 7; r++) tick();
      dump_ready = 0;
      checks++;
      if (dump_valid !== 1'b1 || dump_data !== 64'h0) begin
         errors++;
         $display("FAIL dump_row7: dump_valid=%b dump_data=%h, required 1 0", dump_valid, dump_data);
      end
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if (load_ready !== 1'b1 || dump_valid !== 1'b0 || solver_en !== 1'b0 || path_len !== 13'd0 || wall_violation !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: load_ready=%b dump_valid=%b solver_en=%b path_len=%0d wv=%b, required 1 0 0 0 0",
                  load_ready, dump_valid, solver_en, path_len, wall_violation);
      end
      $display("mid-dump reset: load_ready=%b dump_valid=%b path_len=%0d", load_ready, dump_valid, path_len);
   endtask

   task automatic test_zero_maze();
      test_load(64'h0, 1'b1);
      done = 1;
      tick();
      done = 0;
      dump_ready = 1;
      for (int r = 0; r < 64; r++) begin
         checks++;
         if (dump_valid !== 1'b1 || dump_data !== 64'h0) begin
            errors++;
            $display("FAIL zero_row%0d: dump_valid=%b dump_data=%h, required 1 0", r, dump_valid, dump_data);
         end
         tick();
      end
      dump_ready = 0;
      checks++;
      if (dump_valid !== 1'b0 || path_len !== 13'd0 || wall_violation !== 1'b0) begin
         errors++;
         $display("FAIL zero_end: dump_valid=%b path_len=%0d wv=%b, required 0 0 0", dump_valid, path_len, wall_violation);
      end
      $display("zero maze dump end: dump_valid=%b path_len=%0d", dump_valid, path_len);
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_load_ignores_solver();
      test_load(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      test_read();
      test_mark();
      test_serve_ignores_load();
      test_done_dump();
      test_finished();
      test_reset_mid_dump();
      test_zero_maze();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/maze_memory.md
Name: maze_memory

Overview:
- Responder side of the maze solver's cell-access interface: holds the maze map and answers the solver's `row`/`col` read (`maze_oe`) and mark (`maze_we`) requests.
- Before solving, the map is loaded one row per handshake; the solver is released via `solver_en`.
- When `done` is seen, the marked path map is streamed out row by row over a valid/ready handshake.
- Sits between the testbench/top-level map source and the solver FSM.

Parameters:
- `maze_width`, 6, bit width of the row/col index.
- `MAZE_SIZE`, 64, cells per row and rows per maze; must equal 2**`maze_width`.
- `LEN_W`, 13, width of `path_len`; must be ≥ 2*`maze_width`+1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `load_valid`  in  1  `load_data` holds the next wall row
- `load_ready`  out  1  block accepts a wall row this cycle
- `load_data`  in  `MAZE_SIZE`  wall row; bit c = cell (current load row, c); 1 = wall, 0 = free
- `row`  in  `maze_width`  solver-selected row
- `col`  in  `maze_width`  solver-selected column
- `maze_oe`  in  1  read request for cell (`row`, `col`)
- `maze_we`  in  1  mark request for cell (`row`, `col`)
- `done`  in  1  solver has found the exit
- `maze_in`  out  1  wall bit of the last read cell
- `solver_en`  out  1  solver may run
- `path_len`  out  `LEN_W`  number of distinct cells marked
- `wall_violation`  out  1  sticky: a wall cell was marked
- `dump_valid`  out  1  `dump_data` holds a path row
- `dump_ready`  in  1  consumer accepts the path row
- `dump_data`  out  `MAZE_SIZE`  path row; bit c = 1 if cell (`dump_row`, c) was marked

Behaviour:
- Storage: `wall[MAZE_SIZE][MAZE_SIZE]` and `path[MAZE_SIZE][MAZE_SIZE]`, one bit each. Internal counters `load_row` and `dump_row`, each `maze_width` bits.
- States: LOAD, SERVE, DUMP, FINISHED.
- Reset (synchronous, takes priority over everything):
  - state = LOAD; `load_row` = 0; `dump_row` = 0.
  - `maze_in` = 0, `solver_en` = 0, `path_len` = 0, `wall_violation` = 0, `dump_valid` = 0, `dump_data` = 0.
  - `load_ready` = 1, since it is combinational (state == LOAD).
  - Wall and path arrays are not cleared by reset.
- LOAD:
  - On a handshake (`load_valid` && `load_ready`):
    - `wall[load_row]` ← `load_data`.
    - `path[load_row]` ← 0.
    - `load_row` increments.
  - The handshake on row `MAZE_SIZE`-1 moves the state to SERVE, with `solver_en` = 1 from the next cycle.
  - Gaps in `load_valid` are allowed.
  - `maze_oe`, `maze_we` and `done` are ignored.
- SERVE:
  - Read: `maze_oe` = 1 at an edge → `maze_in` ← `wall[row][col]`, valid the cycle after the request (1-cycle latency). With `maze_oe` = 0, `maze_in` holds its value.
  - Mark: `maze_we` = 1 at an edge → `path[row][col]` ← 1.
    - `path_len` increments only if the cell was previously unmarked; it saturates at all-ones.
    - If `wall[row][col]` = 1, `wall_violation` ← 1 (sticky until reset); the mark is still applied.
  - Simultaneous `maze_oe` and `maze_we`, any cells: both are served. The read returns the wall bit, which a mark never changes.
  - `done` = 1 at an edge:
    - Any `maze_we` in that same cycle is applied.
    - State moves to DUMP; `solver_en` = 0 and `dump_valid` = 1 with `dump_data` = `path[0]` from the next cycle.
  - `load_valid` is ignored.
- DUMP:
  - On a handshake (`dump_valid` && `dump_ready`), `dump_row` increments and `dump_data` ← `path[dump_row+1]` the next cycle.
  - While `dump_ready` = 0, `dump_data` and `dump_valid` are held stable.
  - The handshake on row `MAZE_SIZE`-1 moves the state to FINISHED with `dump_valid` = 0.
  - `maze_we`, `maze_oe`, `done` and `load_valid` are ignored; the solver's continued `maze_we` at the exit cell has no effect.
- FINISHED:
  - All inputs are ignored; only `rst` leaves this state.
  - `path_len` and `wall_violation` hold their final values.
- Reset mid-operation from any state returns to LOAD. Stale path bits are cleared row by row as the new maze loads.
- Index width: `row`/`col` are exactly `maze_width` bits, so every index addresses a valid cell; no out-of-range case exists.

Test Plan:
- Reset, then load 64 rows: all `64'hFFFF_FFFF_FFFF_FFFF` except row 5 = `64'h0`, inserting a 2-cycle `load_valid` gap at row 10 → `load_ready` drops after the 64th handshake; `solver_en` = 1 the following cycle.
- SERVE: `maze_oe` at (5,10) → `maze_in` = 0 next cycle; `maze_oe` at (4,10) → `maze_in` = 1; two idle cycles → `maze_in` stays 1.
- `maze_we` at (5,10) twice, then (5,11) → `path_len` = 2, `wall_violation` = 0. Then `maze_we` at (4,10) → `path_len` = 3, `wall_violation` = 1. Same-cycle `maze_oe`+`maze_we` at (5,12) → `maze_in` = 0, `path_len` = 4.
- `done` = 1 with `maze_we` at (5,13) in the same cycle → `path_len` = 5; `solver_en` = 0 and `dump_valid` = 1 next cycle; `dump_data` for row 0 = 0. Hold `dump_ready` = 0 for 3 cycles → data stable. Row 4 = bit 10 set; row 5 = bits 10–13 set. After row 63 → `dump_valid` = 0, state FINISHED; further `maze_we` leaves `path_len` = 5.
- Assert `rst` while `dump_valid` = 1 at row 7 → next cycle `load_ready` = 1, `dump_valid` = 0, `solver_en` = 0, `path_len` = 0, `wall_violation` = 0. Reload all-zero walls, `done` immediately → every dumped row = 0.
- `load_valid` = 1 during SERVE, and `maze_we` during LOAD → no change to map, `path_len` or state.
